// File: rtl/ext_mem_pkg.sv
// rtl/ext_mem_pkg.sv - shared types and constants for the external-memory responder
package ext_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_DEPTH_LOG2  = 10;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/ext_mem_ram.sv
// rtl/ext_mem_ram.sv - synchronous single-port word RAM, read every cycle, no reset
module ext_mem_ram
    import ext_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    // Read-before-write: rdata_q reflects the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// rtl/ext_mem_responder.sv - wait-stated external-memory responder; EXT_MEM_RESP_ERR_EN adds range checking and err
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int COUNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
`ifdef EXT_MEM_RESP_ERR_EN
    output logic        busy,
    output logic        err
`else
    output logic        busy
`endif
);

    localparam logic [COUNT_W-1:0] CNT_LOAD =
        COUNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e                state_q, state_d;
    logic [COUNT_W-1:0]    cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  oor_q, oor_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic                  req;
    logic                  addr_oor;
    logic                  oor_in;
    logic                  ram_we;
    logic [31:0]           ram_rdata;

    assign req      = cs & (rd_en | wr_en);
    assign addr_oor = (|addr[31:DEPTH_LOG2+2]) | (|addr[1:0]);

`ifdef EXT_MEM_RESP_ERR_EN
    assign oor_in = addr_oor;
    assign err    = err_q;
`else
    logic unused_bits;
    assign oor_in      = 1'b0;
    assign unused_bits = addr_oor ^ err_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = addr[DEPTH_LOG2+1:2];
                    wr_d    = wr_en;
                    wdata_d = wdata;
                    oor_d   = oor_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                err_d   = oor_q;
                if (wr_q) begin
                    ram_we = ~oor_q;
                end else begin
                    rdata_d = oor_q ? ERR_DATA : ram_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Addressed with idx_d so the word is already fetched when DONE is reached, even with no wait states.
    ext_mem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (idx_d),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb/tb_ext_mem_responder.sv - directed self-checking bench for ext_mem_responder
module tb_ext_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cs_a = 1'b0, rd_a = 1'b0, wr_a = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0;
    logic [31:0] rdata_a;
    logic        ready_a, busy_a;

    logic        cs_b = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
    logic [31:0] addr_b = '0, wdata_b = '0;
    logic [31:0] rdata_b;
    logic        ready_b, busy_b;

    int n_vec = 0;
    int n_err = 0;

`ifdef EXT_MEM_RESP_ERR_EN
    logic err_a, err_b;
    localparam logic [31:0] EXP_1000  = 32'hDEADBEEF;
    localparam logic [31:0] EXP_ALIAS = 32'hDEADBEEF;
`else
    localparam logic [31:0] EXP_1000  = 32'h1111_1111;
    localparam logic [31:0] EXP_ALIAS = 32'h1234_5678;
`endif

    always #5 clk = ~clk;

    ext_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .COUNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .cs(cs_a), .addr(addr_a), .rd_en(rd_a),
        .wr_en(wr_a), .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a),
`ifdef EXT_MEM_RESP_ERR_EN
        .busy(busy_a), .err(err_a)
`else
        .busy(busy_a)
`endif
    );

    ext_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .COUNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cs(cs_b), .addr(addr_b), .rd_en(rd_b),
        .wr_en(wr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b),
`ifdef EXT_MEM_RESP_ERR_EN
        .busy(busy_b), .err(err_b)
`else
        .busy(busy_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // WAIT_CYCLES=2: accept at E0, busy for two cycles, ready after E3.
    task automatic access_a(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rdata, input string tag);
        cs_a = 1'b1; wr_a = wr; rd_a = rd; addr_a = a; wdata_a = d;
        tick();
        chk({tag, " busy e0"}, 32'(busy_a), 32'd1);
        chk({tag, " ready e0"}, 32'(ready_a), 32'd0);
        tick();
        chk({tag, " busy e1"}, 32'(busy_a), 32'd1);
        tick();
        chk({tag, " busy e2"}, 32'(busy_a), 32'd0);
        chk({tag, " ready e2"}, 32'(ready_a), 32'd0);
        tick();
        chk({tag, " ready e3"}, 32'(ready_a), 32'd1);
        chk({tag, " rdata"}, rdata_a, exp_rdata);
        cs_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0;
        tick();
        chk({tag, " ready e4"}, 32'(ready_a), 32'd0);
    endtask

    task automatic access_b(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rdata, input string tag);
        cs_b = 1'b1; wr_b = wr; rd_b = rd; addr_b = a; wdata_b = d;
        tick();
        chk({tag, " ready e0"}, 32'(ready_b), 32'd0);
        chk({tag, " busy e0"}, 32'(busy_b), 32'd0);
        tick();
        chk({tag, " ready e1"}, 32'(ready_b), 32'd1);
        chk({tag, " rdata"}, rdata_b, exp_rdata);
        cs_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
        tick();
        chk({tag, " ready e2"}, 32'(ready_b), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_cnt;

        tick();
        chk("reset rdata", rdata_a, 32'h0);
        chk("reset ready", 32'(ready_a), 32'd0);
        chk("reset busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        tick();

        access_a(1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 32'h0, "wr 1000");
        access_a(1'b0, 1'b1, 32'h0000_1000, 32'h0, EXP_1000, "rd 1000");

        cs_a = 1'b1; wr_a = 1'b1; addr_a = 32'h0000_1000; wdata_a = 32'hBAD0_BAD0;
        tick();
        tick();
        chk("abort busy before", 32'(busy_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort ready", 32'(ready_a), 32'd0);
        chk("abort busy", 32'(busy_a), 32'd0);
        chk("abort rdata", rdata_a, 32'h0);
        tick();
        rst_n = 1'b1;
        cs_a = 1'b0; wr_a = 1'b0;
        tick();
        access_a(1'b0, 1'b1, 32'h0000_1000, 32'h0, EXP_1000, "rd after abort");

        access_a(1'b1, 1'b0, 32'h0000_0E00, 32'h1234_5678, EXP_1000, "wr 0e00");
        access_a(1'b0, 1'b1, 32'h0000_0E00, 32'h0, 32'h1234_5678, "rd 0e00");

        cs_a = 1'b0; rd_a = 1'b1; addr_a = 32'h0000_0B00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("cs0 busy", 32'(busy_a), 32'd0);
            chk("cs0 ready", 32'(ready_a), 32'd0);
        end
        chk("cs0 rdata", rdata_a, 32'h1234_5678);
        rd_a = 1'b0;

        access_a(1'b1, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 32'h1234_5678, "rdwr 0004");
        access_a(1'b0, 1'b1, 32'h0000_0004, 32'h0, 32'hA5A5_A5A5, "rd 0004");

        cs_a = 1'b1; rd_a = 1'b1; addr_a = 32'h0000_0E00;
        tick();
        cs_a = 1'b0; rd_a = 1'b0;
        tick();
        ready_cnt = 0;
        cs_a = 1'b1; wr_a = 1'b1; addr_a = 32'h0000_0004; wdata_a = 32'hFFFF_FFFF;
        tick();
        ready_cnt += int'(ready_a);
        cs_a = 1'b0; wr_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ready_cnt += int'(ready_a);
        end
        chk("busy pulse ready count", 32'(ready_cnt), 32'd1);
        chk("busy pulse rdata", rdata_a, 32'h1234_5678);
        access_a(1'b0, 1'b1, 32'h0000_0004, 32'h0, 32'hA5A5_A5A5, "rd 0004 kept");

`ifdef EXT_MEM_RESP_ERR_EN
        cs_a = 1'b1; rd_a = 1'b1; addr_a = 32'hFFFF_0E00;
        tick(); tick(); tick(); tick();
        chk("oor ready", 32'(ready_a), 32'd1);
        chk("oor err", 32'(err_a), 32'd1);
        chk("oor rdata", rdata_a, EXP_ALIAS);
        cs_a = 1'b0; rd_a = 1'b0;
        tick();
        chk("oor err clear", 32'(err_a), 32'd0);
`else
        access_a(1'b0, 1'b1, 32'hFFFF_0E00, 32'h0, EXP_ALIAS, "alias ffff0e00");
`endif

        access_b(1'b1, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, "w0 wr 0008");
        access_b(1'b0, 1'b1, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, "w0 rd 0008");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
